// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: operand FIFO feeding the iterative GCD core via CORE_RESET/READY.
// Ports: IN_* upstream valid/ready, CORE_* core side, RES_* result valid/ack,
// BUSY, JOBS_DONE. Define JOBSEQ_TIMEOUT_EN to enable the RUN watchdog.
module gcd_job_sequencer #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_X,
  input  logic [WIDTH-1:0] IN_Y,
  output logic [WIDTH-1:0] CORE_X,
  output logic [WIDTH-1:0] CORE_Y,
  output logic             CORE_RESET,
  input  logic [WIDTH-1:0] CORE_OUT,
  input  logic             CORE_READY,
  output logic             RES_VALID,
  output logic [WIDTH-1:0] RES_DATA,
  input  logic             RES_ACK,
  output logic             RES_TIMEOUT,
  output logic             BUSY,
  output logic [7:0]       JOBS_DONE
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_CAPTURE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_x_q [DEPTH];
  logic [WIDTH-1:0] mem_x_d [DEPTH];
  logic [WIDTH-1:0] mem_y_q [DEPTH];
  logic [WIDTH-1:0] mem_y_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] core_x_q, core_x_d;
  logic [WIDTH-1:0] core_y_q, core_y_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [7:0]       jobs_q, jobs_d;
  logic             push;
  logic             pop;
  logic             abort;

`ifdef JOBSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          abort_q, abort_d;
  logic          res_to_q, res_to_d;

  assign abort       = abort_q;
  assign RES_TIMEOUT = res_to_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmr_q    <= '0;
      abort_q  <= 1'b0;
      res_to_q <= 1'b0;
    end else begin
      tmr_q    <= tmr_d;
      abort_q  <= abort_d;
      res_to_q <= res_to_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign abort          = 1'b0;
  assign RES_TIMEOUT    = 1'b0;
`endif

  // Ready is forced low while reset is held.
  assign IN_READY   = RESET_N && (cnt_q != FULL_CNT);
  assign push       = IN_VALID && IN_READY;
  assign pop        = (state_q == S_IDLE) && (cnt_q != '0);
  assign CORE_RESET = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign CORE_X     = core_x_q;
  assign CORE_Y     = core_y_q;
  assign RES_VALID  = res_valid_q;
  assign RES_DATA   = res_data_q;
  assign JOBS_DONE  = jobs_q;
  assign BUSY       = (state_q != S_IDLE) || (cnt_q != '0);

  always_comb begin
    state_d     = state_q;
    mem_x_d     = mem_x_q;
    mem_y_d     = mem_y_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    core_x_d    = core_x_q;
    core_y_d    = core_y_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    jobs_d      = jobs_q;
`ifdef JOBSEQ_TIMEOUT_EN
    tmr_d       = tmr_q;
    abort_d     = abort_q;
    res_to_d    = res_to_q;
`endif

    if (push) begin
      mem_x_d[wr_ptr_q] = IN_X;
      mem_y_d[wr_ptr_q] = IN_Y;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    // Ack drops the held result; a capture below may refill it.
    if (RES_ACK) begin
      res_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          core_x_d = mem_x_q[rd_ptr_q];
          core_y_d = mem_y_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_RUN;
`ifdef JOBSEQ_TIMEOUT_EN
        tmr_d   = '0;
        abort_d = 1'b0;
`endif
      end
      S_RUN: begin
        if (CORE_READY) begin
          state_d = S_CAPTURE;
        end
`ifdef JOBSEQ_TIMEOUT_EN
        else if (tmr_q == TMR_LAST) begin
          state_d = S_CAPTURE;
          abort_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
`endif
      end
      S_CAPTURE: begin
        // Core is not cleared here, so OUT stays valid while stalled.
        if (!res_valid_q || RES_ACK) begin
          res_valid_d = 1'b1;
          res_data_d  = abort ? '0 : CORE_OUT;
          jobs_d      = jobs_q + 8'd1;
          state_d     = S_IDLE;
`ifdef JOBSEQ_TIMEOUT_EN
          res_to_d    = abort_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_x_q[i] <= '0;
        mem_y_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      core_x_q    <= '0;
      core_y_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_x_q     <= mem_x_d;
      mem_y_q     <= mem_y_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      core_x_q    <= core_x_d;
      core_y_q    <= core_y_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      jobs_q      <= jobs_d;
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb_gcd_job_sequencer: random and directed jobs against a behavioural
// subtractive GCD core; results checked against a Euclid reference queue.
module tb_gcd_job_sequencer;

  localparam int TO = 20;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] core_x;
  logic [15:0] core_y;
  logic        core_reset;
  logic [15:0] core_out;
  logic        core_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ack;
  logic        res_timeout;
  logic        busy;
  logic [7:0]  jobs_done;

  int n_chk;
  int n_fail;
  int n_pushed;
  bit exp_abort;
  bit stuck;
  int exp_d[$];
  int exp_t[$];

  gcd_job_sequencer #(
    .WIDTH(16),
    .DEPTH(4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .IN_X(in_x),
    .IN_Y(in_y),
    .CORE_X(core_x),
    .CORE_Y(core_y),
    .CORE_RESET(core_reset),
    .CORE_OUT(core_out),
    .CORE_READY(core_ready),
    .RES_VALID(res_valid),
    .RES_DATA(res_data),
    .RES_ACK(res_ack),
    .RES_TIMEOUT(res_timeout),
    .BUSY(busy),
    .JOBS_DONE(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] gx;
  logic [15:0] gy;

  always @(posedge clk) begin
    if (core_reset) begin
      gx <= core_x;
      gy <= core_y;
    end else if (gx != gy) begin
      if (gx > gy) gx <= gx - gy;
      else gy <= gy - gx;
    end
  end

  assign core_out   = gx;
  assign core_ready = (gx == gy) && !stuck;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic model_push(input logic [15:0] x, input logic [15:0] y);
    exp_d.push_back(exp_abort ? 0 : gcd_ref(int'(x), int'(y)));
    exp_t.push_back(exp_abort ? 1 : 0);
    n_pushed++;
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y);
    int b;
    b = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    while (!in_ready && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    else model_push(x, y);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_d.size() != 0; i++) @(negedge clk);
    check(tag, exp_d.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !res_valid; i++) @(negedge clk);
    check(tag, res_valid, 1);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (rst_n && res_valid && res_ack) begin
      if (exp_d.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("res_data", res_data, exp_d.pop_front());
        check("res_timeout", res_timeout, exp_t.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] d0;
    logic [7:0]  jd;
    bit          ok;
    bit          acc;
    int          sent;
    int          lows;

    n_chk = 0;
    n_fail = 0;
    n_pushed = 0;
    exp_abort = 0;
    stuck = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    res_ack = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_core_reset", core_reset, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_jobs", jobs_done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_core_x", core_x, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    res_ack = 1'b1;
    push(16'd123, 16'd456);
    check("single_cr_idle", core_reset, 1);
    @(negedge clk);
    check("single_cr_load", core_reset, 1);
    check("single_core_x", core_x, 123);
    check("single_core_y", core_y, 456);
    @(negedge clk);
    check("single_cr_settle", core_reset, 0);
    ok = 1;
    for (int i = 0; i < 2000 && !res_valid; i++) begin
      if (core_reset) ok = 0;
      @(negedge clk);
    end
    check("single_cr_low", ok, 1);
    check("single_valid", res_valid, 1);
    check("single_data", res_data, gcd_ref(123, 456));
    check("single_cr_back", core_reset, 1);
    check("single_jobs", jobs_done, 1);
    @(negedge clk);
    check("single_pulse", res_valid, 0);
    drain("single_drain", 50);

    res_ack = 1'b0;
    push(16'd123, 16'd456);
    push(16'd456, 16'd123);
    wait_valid("bp_first_valid", 2000);
    d0 = res_data;
    check("bp_first_data", d0, gcd_ref(123, 456));
    jd = jobs_done;
    ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (!res_valid || res_data != d0) ok = 0;
    end
    check("bp_hold", ok, 1);
    check("bp_stall_jobs", jobs_done, jd);
    check("bp_busy", busy, 1);
    push(16'd123, 16'd456);
    push(16'd456, 16'd123);
    push(16'd123, 16'd122);
    push(16'd48, 16'd18);
    check("burst_full", in_ready, 0);
    res_ack = 1'b1;
    @(negedge clk);
    check("bp_next_valid", res_valid, 1);
    check("bp_next_data", res_data, gcd_ref(456, 123));
    check("bp_next_jobs", jobs_done, 8'(jd + 8'd1));
    drain("burst_drain", 3000);
    check("burst_jobs", jobs_done, n_pushed % 256);

    sent = 0;
    for (int c = 0; c < 6000 && (sent < 20 || in_valid); c++) begin
      res_ack = 1'($urandom_range(0, 1));
      if (!in_valid && sent < 20 && $urandom_range(0, 2) == 0) begin
        in_x = 16'($urandom_range(1, 200));
        in_y = 16'($urandom_range(1, 200));
        in_valid = 1'b1;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        model_push(in_x, in_y);
        sent++;
      end
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    check("rand_sent", sent, 20);
    res_ack = 1'b1;
    drain("rand_drain", 6000);
    check("rand_jobs", jobs_done, n_pushed % 256);
    check("rand_idle", busy, 0);

    stuck = 1;
    push(16'd5, 16'd10);
    repeat (6) @(negedge clk);
    check("mid_in_run", core_reset, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_core_reset", core_reset, 1);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_jobs", jobs_done, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_d.delete();
    exp_t.delete();
    n_pushed = 0;
    stuck = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int j = 0; j < 256; j++) push(16'd1, 16'd1);
    drain("wrap_drain", 3000);
    check("wrap_jobs", jobs_done, n_pushed % 256);

`ifdef JOBSEQ_TIMEOUT_EN
    stuck = 1;
    exp_abort = 1;
    push(16'd123, 16'd456);
    exp_abort = 0;
    lows = 0;
    for (int i = 0; i < 300 && !res_valid; i++) begin
      if (!core_reset) lows++;
      @(negedge clk);
    end
    check("to_valid", res_valid, 1);
    check("to_flag", res_timeout, 1);
    check("to_data", res_data, 0);
    check("to_run_len", lows, TO + 2);
    stuck = 0;
    push(16'd48, 16'd18);
    drain("to_drain", 2000);
    check("to_jobs", jobs_done, n_pushed % 256);
    check("to_clear", res_timeout, 0);
`else
    lows = 0;
    check("no_to_flag", res_timeout, lows);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
Initiator side of the start/READY handshake used by the team's 16-bit iterative GCD core. Accepts operand pairs from an upstream valid/ready stream into a small FIFO and launches each job on the core by pulsing the core's clear/start. It then waits for the core's READY, captures OUT and presents the result downstream with valid/ack. It replaces hand-sequenced bench stimulus with a reusable hardware front end.

Parameters:
WIDTH, 16, operand/result width (matches core)
DEPTH, 4, operand FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 1023, watchdog limit in RUN (used only with JOBSEQ_TIMEOUT_EN)

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  asynchronous active-low reset
IN_VALID  in  1  operand pair offered
IN_READY  out  1  FIFO not full
IN_X  in  WIDTH  operand X
IN_Y  in  WIDTH  operand Y
CORE_X  out  WIDTH  operand X to core
CORE_Y  out  WIDTH  operand Y to core
CORE_RESET  out  1  active-high clear/start to core
CORE_OUT  in  WIDTH  core result
CORE_READY  in  1  core done
RES_VALID  out  1  result held
RES_DATA  out  WIDTH  captured result
RES_ACK  in  1  downstream consumes result
RES_TIMEOUT  out  1  held result is an aborted job (0 when feature disabled)
BUSY  out  1  state != IDLE or FIFO non-empty
JOBS_DONE  out  8  completed-job count, wraps 255->0

Behaviour:
- Reset (async, RESET_N=0): FIFO empty, state IDLE, CORE_RESET=1, CORE_X=CORE_Y=0, RES_VALID=0, RES_DATA=0, RES_TIMEOUT=0, JOBS_DONE=0, IN_READY=0 while in reset, then 1. Reset mid-job abandons the job; no result is produced.
- FIFO: push when IN_VALID&&IN_READY; IN_READY=!full. There is no full-bypass, so a push and pop in the same cycle while full is not accepted. Wrap-around pointers with count 0..DEPTH.
- FSM states IDLE, LOAD, SETTLE, RUN, CAPTURE:
  - IDLE: CORE_RESET=1. If FIFO non-empty, pop head into CORE_X/CORE_Y and go to LOAD.
  - LOAD: one cycle, CORE_RESET=1, operands stable. Go to SETTLE.
  - SETTLE: one cycle, CORE_RESET=0, CORE_READY ignored. Go to RUN.
  - RUN: CORE_RESET=0. On sampled CORE_READY=1, go to CAPTURE.
  - CAPTURE: if RES_VALID=0, or RES_VALID=1 with RES_ACK=1 this cycle, load RES_DATA<=CORE_OUT, set RES_VALID, increment JOBS_DONE, go to IDLE. Otherwise stall in CAPTURE; the core holds OUT because it is not cleared.
- CORE_X/CORE_Y change only on the IDLE->LOAD transition and are held through CAPTURE.
- Output handshake: RES_VALID falls the cycle after RES_ACK=1 unless a new capture occurs in the same cycle, in which case RES_VALID stays 1 with the new data. RES_ACK with RES_VALID=0 is ignored.
- Latency: with FIFO non-empty and the FSM in IDLE, CORE_RESET first falls 2 cycles after the pop. RES_VALID rises 1 cycle after CORE_READY is sampled high (plus any stall).
- Back-to-back jobs: minimum 4 cycles of overhead between core completions, in addition to core compute time.

Optional Feature:
JOBSEQ_TIMEOUT_EN
- Defined: a counter clears on entry to RUN and increments each RUN cycle. If it reaches TIMEOUT_CYCLES without CORE_READY, the FSM goes to CAPTURE as an aborted job: RES_DATA=0, RES_TIMEOUT=1, JOBS_DONE still increments. RES_TIMEOUT=0 for normal results.
- Undefined: no counter, RUN waits indefinitely, RES_TIMEOUT tied 0.

Test Plan:
- Reset: hold RESET_N=0 -> CORE_RESET=1, RES_VALID=0, BUSY=0, JOBS_DONE=0; async assert mid-RUN clears all of these immediately.
- Single job (123,456), with the GCD core attached and RES_ACK tied 1 -> RES_DATA=3, one-cycle RES_VALID pulse, JOBS_DONE=1; CORE_RESET low exactly from 2 cycles after the pop until return to IDLE.
- Burst of 4 pushes (123,456),(456,123),(123,122),(48,18) -> IN_READY=0 after 4th push while the first job is still queued; results 3,3,1,6 in order; JOBS_DONE=4.
- Backpressure: RES_ACK=0 for 50 cycles with 2 jobs queued -> first result 3 held stable, FSM stalls in CAPTURE for job 2. Ack -> second result 3 appears the cycle after the ack cycle.
- JOBS_DONE wrap: 256 jobs of (1,1) -> count returns to 0, every result 1.
- JOBSEQ_TIMEOUT_EN, TIMEOUT_CYCLES=20, CORE_READY stuck 0 -> RES_VALID=1, RES_TIMEOUT=1, RES_DATA=0 after 20 RUN cycles; the next job with a working core gives RES_TIMEOUT=0.
